// File: rtl/program_counter.sv
// Program counter for the 8-bit processor: selects increment, jump, branch, call and return,
// with a small return-address stack and an INIT/RUN/HALT control FSM.
//
// state  | meaning
// INIT   | out of reset, waiting for the first clock edge; PC not yet valid
// RUN    | fetching; PC updates every unstalled cycle
// HALT   | stopped by halt request or stack error; waits for resume
module program_counter #(
  parameter int ADDR_W      = 8,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] next_addr_in,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              halted,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_valid;
  logic              r_halted;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [SP_W-1:0]   w_sp_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = r_sp[IDX_W-1:0];
  // When full the low bits wrap to 0, so subtracting one still lands on the top entry.
  assign w_top_idx  = r_sp[IDX_W-1:0] - IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (!stall) begin
      case (r_state)
        S_INIT: w_state_nxt = S_RUN;
        S_RUN: begin
          if (halt) begin
            w_state_nxt = S_HALT;
          end else if (ret) begin
            if (w_empty) begin
              w_unf_nxt   = 1'b1;
              w_state_nxt = S_HALT;
            end else begin
              w_pc_nxt = r_stack[w_top_idx];
              w_sp_nxt = r_sp - SP_W'(1);
            end
          end else if (call) begin
            if (w_full) begin
              w_ovf_nxt   = 1'b1;
              w_state_nxt = S_HALT;
            end else begin
              w_push   = 1'b1;
              w_pc_nxt = target_addr;
              w_sp_nxt = r_sp + SP_W'(1);
            end
          end else if (jump || (branch && branch_taken)) begin
            w_pc_nxt = target_addr;
          end else begin
            w_pc_nxt = next_addr_in;
          end
        end
        S_HALT: begin
          if (resume) begin
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_INIT;
      r_pc     <= ADDR_W'(RESET_ADDR);
      r_sp     <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_sp     <= w_sp_nxt;
      r_valid  <= (w_state_nxt == S_RUN);
      r_halted <= (w_state_nxt == S_HALT);
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
    end
  end

  // Stack storage is deliberately left out of reset; only the pointer matters.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= next_addr_in;
    end
  end

  assign pc_out          = r_pc;
  assign pc_valid        = r_valid;
  assign halted          = r_halted;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule
